// File: rtl/cv32e40p_apu_arbiter.sv
// Shares one APU/FPU between NUM_CORES cores: round-robin request arbitration with a
// request-hold lock, and an in-order ID FIFO that routes each response to its issuer.
module cv32e40p_apu_arbiter #(
  parameter int NUM_CORES       = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter int NARGS           = 3,
  parameter int WOP             = 6,
  parameter int NDSFLAGS        = 15,
  parameter int NUSFLAGS        = 5
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic [NUM_CORES-1:0]                   core_req_i,
  output logic [NUM_CORES-1:0]                   core_gnt_o,
  input  logic [NUM_CORES*NARGS*32-1:0]          core_operands_i,
  input  logic [NUM_CORES*WOP-1:0]               core_op_i,
  input  logic [NUM_CORES*NDSFLAGS-1:0]          core_flags_i,
  output logic [NUM_CORES-1:0]                   core_rvalid_o,
  output logic [31:0]                            core_result_o,
  output logic [NUSFLAGS-1:0]                    core_flags_o,
  output logic                                   fpu_req_o,
  input  logic                                   fpu_gnt_i,
  output logic [NARGS*32-1:0]                    fpu_operands_o,
  output logic [WOP-1:0]                         fpu_op_o,
  output logic [NDSFLAGS-1:0]                    fpu_flags_o,
  input  logic                                   fpu_rvalid_i,
  input  logic [31:0]                            fpu_result_i,
  input  logic [NUSFLAGS-1:0]                    fpu_flags_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
  output logic                                   resp_err_o
);

  localparam int IW  = $clog2(NUM_CORES);
  localparam int CW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int OPW = NARGS * 32;

  // Handshake: a request transfers in the cycle where req and gnt are both high; once
  // raised, req and its payload hold until that cycle. rvalid is a single-cycle strobe.

  logic [IW-1:0] rr_ptr_q;
  logic          lock_q;
  logic [IW-1:0] lock_id_q;
  logic          lock_d;
  logic [IW-1:0] lock_id_d;
  logic          lock_live;
  logic [IW-1:0] scan_idx;
  logic [IW-1:0] rr_winner;
  logic [IW-1:0] winner;
  logic          any_req;
  logic          full;
  logic          grant;
  logic          pop;
  logic [IW-1:0] fifo_q [MAX_OUTSTANDING];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [IW-1:0] head;
  logic          resp_err_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
  endfunction

  // First requester at or after rr_ptr, wrapping around the core list.
  always_comb begin
    any_req   = 1'b0;
    rr_winner = '0;
    scan_idx  = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      scan_idx = IW'((32'(rr_ptr_q) + 32'(i)) % 32'(NUM_CORES));
      if (!any_req && core_req_i[scan_idx]) begin
        any_req   = 1'b1;
        rr_winner = scan_idx;
      end
    end
  end

  // A lock whose owner withdrew its request is ignored so arbitration restarts at once.
  assign lock_live = lock_q && core_req_i[lock_id_q];
  assign winner    = lock_live ? lock_id_q : rr_winner;
  assign full      = (count_q == CW'(MAX_OUTSTANDING));
  assign fpu_req_o = any_req && !full;
  assign grant     = fpu_req_o && fpu_gnt_i;
  assign pop       = fpu_rvalid_i && (count_q != '0);
  assign head      = fifo_q[rd_ptr_q];

  always_comb begin
    fpu_operands_o = '0;
    fpu_op_o       = '0;
    fpu_flags_o    = '0;
    core_gnt_o     = '0;
    core_rvalid_o  = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      if (any_req && (winner == IW'(k))) begin
        fpu_operands_o = core_operands_i[k*OPW +: OPW];
        fpu_op_o       = core_op_i[k*WOP +: WOP];
        fpu_flags_o    = core_flags_i[k*NDSFLAGS +: NDSFLAGS];
      end
      core_gnt_o[k]    = grant && (winner == IW'(k));
      core_rvalid_o[k] = pop && (head == IW'(k));
    end
  end

  // While full no request reaches the FPU, so an existing lock must survive that stall.
  always_comb begin
    lock_d    = 1'b0;
    lock_id_d = lock_id_q;
    if (lock_live && full) begin
      lock_d = 1'b1;
    end else if (fpu_req_o && !fpu_gnt_i) begin
      lock_d    = 1'b1;
      lock_id_d = winner;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q   <= '0;
      lock_q     <= 1'b0;
      lock_id_q  <= '0;
      resp_err_q <= 1'b0;
    end else begin
      lock_q     <= lock_d;
      lock_id_q  <= lock_id_d;
      resp_err_q <= fpu_rvalid_i && (count_q == '0);
      if (grant) begin
        rr_ptr_q <= (winner == IW'(NUM_CORES - 1)) ? '0 : winner + IW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      if (grant) begin
        fifo_q[wr_ptr_q] <= winner;
        wr_ptr_q         <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      if (grant && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (!grant && pop) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  assign core_result_o = fpu_result_i;
  assign core_flags_o  = fpu_flags_i;
  assign outstanding_o = count_q;
  assign resp_err_o    = resp_err_q;

endmodule

// File: tb/tb_cv32e40p_apu_arbiter.sv
// Bench for cv32e40p_apu_arbiter: directed vector table, hand-written reset/lock/streaming
// sequences, then randomized traffic against a queue-based reference model.
module tb_cv32e40p_apu_arbiter;

  localparam int NC   = 4;
  localparam int MAXO = 2;
  localparam int NARGS = 3;
  localparam int WOP  = 6;
  localparam int NDS  = 15;
  localparam int NUS  = 5;
  localparam int OW   = $clog2(MAXO + 1);
  localparam int OPW  = NARGS * 32;

  logic              clk;
  logic              rst_ni;
  logic [NC-1:0]     core_req;
  logic [NC-1:0]     core_gnt;
  logic [NC*OPW-1:0] core_operands;
  logic [NC*WOP-1:0] core_op;
  logic [NC*NDS-1:0] core_flags_in;
  logic [NC-1:0]     core_rvalid;
  logic [31:0]       core_result;
  logic [NUS-1:0]    core_flags_out;
  logic              fpu_req;
  logic              fpu_gnt;
  logic [OPW-1:0]    fpu_operands;
  logic [WOP-1:0]    fpu_op;
  logic [NDS-1:0]    fpu_flags_out;
  logic              fpu_rvalid;
  logic [31:0]       fpu_result;
  logic [NUS-1:0]    fpu_flags_in;
  logic [OW-1:0]     outstanding;
  logic              resp_err;

  cv32e40p_apu_arbiter #(
    .NUM_CORES(NC), .MAX_OUTSTANDING(MAXO), .NARGS(NARGS),
    .WOP(WOP), .NDSFLAGS(NDS), .NUSFLAGS(NUS)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .core_req_i(core_req), .core_gnt_o(core_gnt),
    .core_operands_i(core_operands), .core_op_i(core_op), .core_flags_i(core_flags_in),
    .core_rvalid_o(core_rvalid), .core_result_o(core_result), .core_flags_o(core_flags_out),
    .fpu_req_o(fpu_req), .fpu_gnt_i(fpu_gnt),
    .fpu_operands_o(fpu_operands), .fpu_op_o(fpu_op), .fpu_flags_o(fpu_flags_out),
    .fpu_rvalid_i(fpu_rvalid), .fpu_result_i(fpu_result), .fpu_flags_i(fpu_flags_in),
    .outstanding_o(outstanding), .resp_err_o(resp_err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- reference model ----------------
  logic [1:0] exp_q[$];   // scoreboard: issuing core of each granted, unanswered op
  int m_rr;
  bit m_lock;
  int m_lock_id;
  bit m_err;

  task automatic model_reset();
    exp_q.delete();
    m_rr = 0; m_lock = 1'b0; m_lock_id = 0; m_err = 1'b0;
  endtask

  function automatic int model_winner();
    if (m_lock && core_req[m_lock_id]) return m_lock_id;
    for (int off = 0; off < NC; off++) begin
      int k = (m_rr + off) % NC;
      if (core_req[k]) return k;
    end
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [NC-1:0] req, input logic gnt, input logic rv);
    core_req   = req;
    fpu_gnt    = gnt;
    fpu_rvalid = rv;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic apply_reset();
    rst_ni = 1'b0;
    drive('0, 1'b0, 1'b0);
    step();
    step();
    rst_ni = 1'b1;
    model_reset();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct packed {
    logic [NC-1:0]  req;
    logic           gnt;
    logic           rv;
    logic           exp_req;
    logic [NC-1:0]  exp_gnt;
    logic [NC-1:0]  exp_rvalid;
    logic [WOP-1:0] exp_op;
    logic [OW-1:0]  exp_out;   // occupancy after the edge
    logic           exp_err;   // resp_err after the edge
  } vec_t;

  localparam int NV = 17;
  vec_t vecs[NV];

  // random-phase working variables
  int            win;
  logic          e_req;
  logic [NC-1:0] e_gnt;
  logic [NC-1:0] e_rv;
  logic [NC-1:0] prev_gnt;
  logic [NC-1:0] nreq;
  logic [OPW-1:0] e_opnd;
  logic [WOP-1:0] e_op;
  logic [NDS-1:0] e_fl;
  bit            was_empty;
  bit            full_now;

  initial begin
    // all requesters at once, responses one cycle behind each grant (push+pop at count=1)
    vecs[0]  = '{4'b1111, 1'b1, 1'b0, 1'b1, 4'b0001, 4'b0000, 6'h11, 2'd1, 1'b0};
    vecs[1]  = '{4'b1110, 1'b1, 1'b1, 1'b1, 4'b0010, 4'b0001, 6'h12, 2'd1, 1'b0};
    vecs[2]  = '{4'b1100, 1'b1, 1'b1, 1'b1, 4'b0100, 4'b0010, 6'h13, 2'd1, 1'b0};
    vecs[3]  = '{4'b1000, 1'b1, 1'b1, 1'b1, 4'b1000, 4'b0100, 6'h14, 2'd1, 1'b0};
    vecs[4]  = '{4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b1000, 6'h00, 2'd0, 1'b0};
    // core 2 held under lock while core 1 joins
    vecs[5]  = '{4'b0100, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 6'h13, 2'd0, 1'b0};
    vecs[6]  = '{4'b0110, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 6'h13, 2'd0, 1'b0};
    vecs[7]  = '{4'b0110, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 6'h13, 2'd0, 1'b0};
    vecs[8]  = '{4'b0110, 1'b1, 1'b0, 1'b1, 4'b0100, 4'b0000, 6'h13, 2'd1, 1'b0};
    vecs[9]  = '{4'b0010, 1'b1, 1'b0, 1'b1, 4'b0010, 4'b0000, 6'h12, 2'd2, 1'b0};
    // full: core 3 blocked, pop does not unblock in the same cycle
    vecs[10] = '{4'b1000, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 6'h14, 2'd2, 1'b0};
    vecs[11] = '{4'b1000, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0100, 6'h14, 2'd1, 1'b0};
    vecs[12] = '{4'b1000, 1'b1, 1'b0, 1'b1, 4'b1000, 4'b0000, 6'h14, 2'd2, 1'b0};
    vecs[13] = '{4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0010, 6'h00, 2'd1, 1'b0};
    vecs[14] = '{4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b1000, 6'h00, 2'd0, 1'b0};
    // response with empty FIFO
    vecs[15] = '{4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 6'h00, 2'd0, 1'b1};
    vecs[16] = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 6'h00, 2'd0, 1'b0};

    core_op       = {6'h14, 6'h13, 6'h12, 6'h11};
    core_operands = '0;
    core_flags_in = '0;
    fpu_result    = '0;
    fpu_flags_in  = '0;
    rst_ni        = 1'b0;
    drive('0, 1'b0, 1'b0);
    step();
    step();

    check("rst_outstanding", outstanding, 0);
    check("rst_resp_err", resp_err, 0);
    check("rst_fpu_req", fpu_req, 0);
    check("rst_core_gnt", core_gnt, 0);
    check("rst_core_rvalid", core_rvalid, 0);
    check("rst_fpu_op", fpu_op, 0);
    rst_ni = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].req, vecs[i].gnt, vecs[i].rv);
      #1;
      check($sformatf("row%0d_fpu_req", i), fpu_req, vecs[i].exp_req);
      check($sformatf("row%0d_core_gnt", i), core_gnt, vecs[i].exp_gnt);
      check($sformatf("row%0d_core_rvalid", i), core_rvalid, vecs[i].exp_rvalid);
      check($sformatf("row%0d_fpu_op", i), fpu_op, vecs[i].exp_op);
      step();
      check($sformatf("row%0d_outstanding", i), outstanding, vecs[i].exp_out);
      check($sformatf("row%0d_resp_err", i), resp_err, vecs[i].exp_err);
    end

    // asynchronous reset with two ops outstanding, then a stale response
    drive(4'b0001, 1'b1, 1'b0);
    step();
    drive(4'b0010, 1'b1, 1'b0);
    step();
    check("t6_pre_outstanding", outstanding, 2);
    drive('0, 1'b0, 1'b0);
    #2 rst_ni = 1'b0;
    #1 check("t6_async_outstanding", outstanding, 0);
    step();
    rst_ni = 1'b1;
    drive('0, 1'b0, 1'b1);
    #1 check("t6_stale_rvalid", core_rvalid, 0);
    step();
    check("t6_stale_err", resp_err, 1);
    drive('0, 1'b0, 1'b0);
    step();
    check("t6_err_clears", resp_err, 0);

    // lock on core 2 must not survive reset
    drive(4'b0100, 1'b0, 1'b0);
    #1 check("lockrst_pre_op", fpu_op, 6'h13);
    step();
    #2 rst_ni = 1'b0;
    #1;
    step();
    rst_ni = 1'b1;
    drive(4'b0110, 1'b1, 1'b0);
    #1 check("lockrst_gnt", core_gnt, 4'b0010);
    step();
    drive('0, 1'b0, 1'b1);
    #1 check("lockrst_rvalid", core_rvalid, 4'b0010);
    step();

    // single requester streams back-to-back
    drive(4'b0010, 1'b1, 1'b0);
    #1 check("single_first_gnt", core_gnt, 4'b0010);
    step();
    for (int i = 0; i < 4; i++) begin
      drive(4'b0010, 1'b1, 1'b1);
      #1;
      check($sformatf("single%0d_gnt", i), core_gnt, 4'b0010);
      check($sformatf("single%0d_rvalid", i), core_rvalid, 4'b0010);
      step();
      check($sformatf("single%0d_outstanding", i), outstanding, 1);
    end
    drive('0, 1'b0, 1'b1);
    step();

    // randomized traffic against the reference model
    apply_reset();
    prev_gnt = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < NC; k++) begin
        if (prev_gnt[k])      nreq[k] = 1'($urandom_range(0, 1));
        else if (core_req[k]) nreq[k] = ($urandom_range(0, 15) != 0);
        else                  nreq[k] = ($urandom_range(0, 2) == 0);
      end
      for (int w = 0; w < NC * NARGS; w++) core_operands[w*32 +: 32] = $urandom();
      core_op       = (NC*WOP)'($urandom());
      core_flags_in = (NC*NDS)'({$urandom(), $urandom()});
      fpu_result    = $urandom();
      fpu_flags_in  = NUS'($urandom());
      drive(nreq, ($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)));
      #1;

      win    = model_winner();
      e_req  = (win >= 0) && (exp_q.size() < MAXO);
      e_gnt  = (e_req && fpu_gnt) ? (NC'(1) << win) : '0;
      e_rv   = (fpu_rvalid && exp_q.size() > 0) ? (NC'(1) << exp_q[0]) : '0;
      e_opnd = (win >= 0) ? core_operands[win*OPW +: OPW] : '0;
      e_op   = (win >= 0) ? core_op[win*WOP +: WOP] : '0;
      e_fl   = (win >= 0) ? core_flags_in[win*NDS +: NDS] : '0;

      check("rnd_fpu_req", fpu_req, e_req);
      check("rnd_core_gnt", core_gnt, e_gnt);
      check("rnd_core_rvalid", core_rvalid, e_rv);
      check("rnd_fpu_operands", fpu_operands, e_opnd);
      check("rnd_fpu_op", fpu_op, e_op);
      check("rnd_fpu_flags", fpu_flags_out, e_fl);
      check("rnd_core_result", core_result, fpu_result);
      check("rnd_core_flags", core_flags_out, fpu_flags_in);
      check("rnd_outstanding", outstanding, exp_q.size());
      check("rnd_resp_err", resp_err, m_err);

      was_empty = (exp_q.size() == 0);
      full_now  = (exp_q.size() >= MAXO);
      if (m_lock && core_req[m_lock_id] && full_now) begin
        m_lock = 1'b1;
      end else if (e_req && !fpu_gnt) begin
        m_lock    = 1'b1;
        m_lock_id = win;
      end else begin
        m_lock = 1'b0;
      end
      if (e_rv != '0) void'(exp_q.pop_front());
      if (e_gnt != '0) begin
        exp_q.push_back(2'(win));
        m_rr = (win + 1) % NC;
      end
      m_err    = fpu_rvalid && was_empty;
      prev_gnt = e_gnt;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
